// File: rtl/expand_pkg.sv
// Shared definitions for the widening integrate-and-dump path: FSM states,
// a constant ceil-log2 helper and an elaboration-time width check.
package expand_pkg;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// The accumulator must hold DUMP_LEN shifted samples without overflow.
`define EXPAND_WIDTH_CHECK(ok_expr) \
  if (!(ok_expr)) begin : g_width_check \
    $error("expand_acc: OUT_WIDTH too small for IN_WIDTH+SHIFT+clog2(DUMP_LEN)"); \
  end

// File: rtl/sxt_shift.sv
// Sign-extends a narrow two's complement sample to the wide domain and shifts
// it left, zero-filling the LSBs. Purely combinational.
module sxt_shift #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 36,
  parameter int SHIFT     = 18
) (
  input  logic signed [IN_WIDTH-1:0]  sample,
  output logic signed [OUT_WIDTH-1:0] wide
);

  logic signed [OUT_WIDTH-1:0] ext_s;

  // sign extension then arithmetic left shift into the wide domain
  always_comb begin
    ext_s = OUT_WIDTH'(sample);
    wide  = ext_s <<< SHIFT;
  end

endmodule

// File: rtl/expand_acc.sv
// Integrate-and-dump of sign-extended, shifted narrow samples. One wide sum
// and OR'd saturation flag per DUMP_LEN-sample block on a registered output.
module expand_acc
  import expand_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 36,
  parameter int SHIFT     = 18,
  parameter int DUMP_LEN  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_sat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_sat
);

  localparam int CNT_W = (clog2(DUMP_LEN) < 1) ? 1 : clog2(DUMP_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DUMP_LEN - 1);

  `EXPAND_WIDTH_CHECK((OUT_WIDTH >= IN_WIDTH + SHIFT + clog2(DUMP_LEN)) && (DUMP_LEN >= 1))

  state_e                      state_r, state_next_s;
  logic signed [OUT_WIDTH-1:0] acc_r;
  logic signed [OUT_WIDTH-1:0] x_s;
  logic [CNT_W-1:0]            cnt_r;
  logic                        sat_acc_r;
  logic                        m_valid_r;
  logic [OUT_WIDTH-1:0]        m_data_r;
  logic                        m_sat_r;
  logic                        at_last_s;
  logic                        accept_s;
  logic                        final_s;

  sxt_shift #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SHIFT    (SHIFT)
  ) u_sxt_shift (
    .sample(s_data),
    .wide  (x_s)
  );

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_sat   = m_sat_r;

  // FSM next state and input-side handshake; FULL parks the final sample
  // until the output register can take it
  always_comb begin
    state_next_s = state_r;
    s_ready      = 1'b1;
    at_last_s    = (cnt_r == LAST);
    case (state_r)
      ST_ACC: begin
        s_ready = !(at_last_s && m_valid_r && !m_ready);
        if (s_ready) begin
          state_next_s = ST_ACC;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      ST_FULL: begin
        s_ready = m_ready || !at_last_s;
        if (s_ready) begin
          state_next_s = ST_ACC;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: begin
        s_ready      = 1'b0;
        state_next_s = ST_ACC;
      end
    endcase
    accept_s = s_valid && s_ready;
    final_s  = accept_s && at_last_s && !restart;
  end

  // state register, block accumulator and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_ACC;
      acc_r     <= '0;
      cnt_r     <= '0;
      sat_acc_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_sat_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;

      if (final_s) begin
        m_data_r  <= acc_r + x_s;
        m_sat_r   <= sat_acc_r | s_sat;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end

      // a sample arriving with restart opens the new block, except when
      // every sample is final, in which case it is discarded
      if (restart) begin
        if (accept_s && (DUMP_LEN > 1)) begin
          acc_r     <= x_s;
          sat_acc_r <= s_sat;
          cnt_r     <= CNT_W'(1);
        end else begin
          acc_r     <= '0;
          sat_acc_r <= 1'b0;
          cnt_r     <= '0;
        end
      end else if (final_s) begin
        acc_r     <= '0;
        sat_acc_r <= 1'b0;
        cnt_r     <= '0;
      end else if (accept_s) begin
        acc_r     <= acc_r + x_s;
        sat_acc_r <= sat_acc_r | s_sat;
        cnt_r     <= cnt_r + CNT_W'(1);
      end else begin
        acc_r     <= acc_r;
        sat_acc_r <= sat_acc_r;
        cnt_r     <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_expand_acc.sv
// Self-checking bench for expand_acc: directed scenarios plus a random phase,
// all compared against a block-sum reference model with an output queue.
module tb_expand_acc;

  localparam int IW = 16;
  localparam int OW = 36;
  localparam int SH = 18;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          restart;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic          s_sat;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          m_sat;

  int checks = 0;
  int errors = 0;

  // reference model: running block sum as a plain integer
  int            mdl_cnt = 0;
  longint        mdl_sum = 0;
  bit            mdl_sat = 1'b0;
  logic [OW-1:0] q_data[$];
  bit            q_sat[$];

  always #5 clk = ~clk;

  expand_acc #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT(SH), .DUMP_LEN(DL)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sat(s_sat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mdl_cnt = 0;
    mdl_sum = 0;
    mdl_sat = 1'b0;
  endtask

  // one clock: drive, check outputs against the model, then advance the model
  task automatic step(input bit v, input logic [IW-1:0] d, input bit st, input bit mr, input bit rs);
    bit exp_rdy;
    bit acc;
    longint xs;
    @(negedge clk);
    s_valid = v; s_data = d; s_sat = st; m_ready = mr; restart = rs;
    #1;
    exp_rdy = !((mdl_cnt == DL - 1) && (q_data.size() != 0) && !mr);
    check_eq("m_valid", m_valid, 64'(q_data.size() != 0));
    check_eq("s_ready", s_ready, 64'(exp_rdy));
    if (q_data.size() != 0) begin
      check_eq("m_data", m_data, q_data[0]);
      check_eq("m_sat", m_sat, q_sat[0]);
      if (mr) begin
        void'(q_data.pop_front());
        void'(q_sat.pop_front());
      end
    end
    acc = v && exp_rdy;
    xs  = longint'($signed(d));
    if (rs) begin
      model_clear();
      if (acc && DL > 1) begin
        mdl_cnt = 1;
        mdl_sum = xs;
        mdl_sat = st;
      end
    end else if (acc) begin
      mdl_cnt++;
      mdl_sum += xs;
      mdl_sat |= st;
      if (mdl_cnt == DL) begin
        q_data.push_back(OW'(mdl_sum * (64'sd1 <<< SH)));
        q_sat.push_back(mdl_sat);
        model_clear();
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic block4(input logic [IW-1:0] a, input logic [IW-1:0] b,
                        input logic [IW-1:0] c, input logic [IW-1:0] d);
    step(1'b1, a, 1'b0, 1'b1, 1'b0);
    step(1'b1, b, 1'b0, 1'b1, 1'b0);
    step(1'b1, c, 1'b0, 1'b1, 1'b0);
    step(1'b1, d, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_sat = 1'b0; m_ready = 1'b0; restart = 1'b0;
    @(negedge clk);
    check_eq("rst_m_valid", m_valid, 64'd0);
    check_eq("rst_m_data", m_data, 64'd0);
    check_eq("rst_m_sat", m_sat, 64'd0);
    check_eq("rst_s_ready", s_ready, 64'd1);
    rst = 1'b0;
    model_clear();
    q_data.delete();
    q_sat.delete();
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; s_valid = 1'b0; s_data = '0; s_sat = 1'b0; m_ready = 1'b0;
    do_reset();

    // basic sum, then extremes
    block4(16'd1, 16'd2, 16'd3, 16'd4);
    idle(2);
    block4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    idle(1);
    block4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    idle(1);
    block4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    idle(1);

    // saturation flag tracks its own block only
    step(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd2, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd4, 1'b0, 1'b1, 1'b0);
    block4(16'd0, 16'd0, 16'd0, 16'd0);
    idle(2);

    // output stall: final sample of block 2 held off until m_ready
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(10 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'd20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'd20, 1'b0, 1'b1, 1'b0);
    idle(2);

    // restart realigns the block on the coinciding sample
    step(1'b1, 16'd5, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd6, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd7, 1'b0, 1'b1, 1'b1);
    step(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd1, 1'b0, 1'b1, 1'b0);
    idle(2);

    // restart on the would-be final sample produces no output
    for (int i = 0; i < 3; i++) step(1'b1, 16'd9, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'd9, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // reset mid-block with a pending output, then a fresh block
    for (int i = 0; i < 6; i++) step(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    do_reset();
    block4(16'd1, 16'd2, 16'd3, 16'd4);
    idle(2);

    // random traffic with stalls, restarts and extreme samples
    for (int i = 0; i < 3000; i++) begin
      logic [IW-1:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h8000;
        1: d = 16'h7FFF;
        default: d = IW'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
    end
    idle(4);
    check_eq("drained", 64'(q_data.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
